seg7_scan: RTL and testbench

//   Time-multiplexed 7-segment driver that displays the BCD digits produced by
//   the cascaded count_10/count_6 time counters on an NUM_DIGITS display.
//   - Internal prescaler sets the per-digit dwell time.
//   - Produces one-cold anode selects and registered active-low segments.
//   - Sits downstream of the counter chain; the board pins are its only consumer.

---
 rtl/seg7_scan.sv | 119 +++++++++++
 tb/tb_seg7_scan.sv | 122 ++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Time-multiplexed, active-low 7-segment scanner driven by a clock prescaler.
// Optional macro SEG7_LZ_BLANK_EN enables leading-zero suppression.
module seg7_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]      div_cnt_r;
    logic [IDX_W-1:0]      idx_r;
    logic                  tick_s;
    logic [IDX_W-1:0]      nxt_s;
    logic [NUM_DIGITS-1:0] sel_s;
    logic [3:0]            nib_s;
    logic                  dpreq_s;
    logic                  suppress_s;

    // Segment pattern {g,f,e,d,c,b,a}, active-low, for one hex nibble.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    // Prescaler tick, next digit index and the selected digit's nibble/dp request.
    always_comb begin
        tick_s  = (div_cnt_r == DIV_LAST);
        nxt_s   = (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        sel_s   = {NUM_DIGITS{1'b0}};
        nib_s   = 4'h0;
        dpreq_s = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_s[i] = (nxt_s == IDX_W'(i));
            nib_s    = nib_s | (digits[4*i +: 4] & {4{sel_s[i]}});
            dpreq_s  = dpreq_s | (dp_in[i] & sel_s[i]);
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic                  lz_run_s;
    logic [NUM_DIGITS-1:0] lz_mask_s;

    // A digit is a leading zero when it and every higher digit are zero; digit 0 never is.
    always_comb begin
        lz_run_s   = 1'b1;
        lz_mask_s  = {NUM_DIGITS{1'b0}};
        suppress_s = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz_run_s     = lz_run_s & (digits[4*i +: 4] == 4'h0);
            lz_mask_s[i] = lz_run_s;
        end
        suppress_s = |(lz_mask_s & sel_s);
    end
`else
    // No leading-zero suppression: every digit decodes as-is.
    always_comb begin
        suppress_s = 1'b0;
    end
`endif

    // Prescaler, scan index and registered display outputs, all updated on tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= {DIV_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            an        <= {NUM_DIGITS{1'b1}};
            seg       <= 7'h7F;
            dp        <= 1'b1;
        end else begin
            div_cnt_r <= tick_s ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
            if (tick_s) begin
                idx_r <= nxt_s;
                if (blank) begin
                    an  <= {NUM_DIGITS{1'b1}};
                    seg <= 7'h7F;
                    dp  <= 1'b1;
                end else begin
                    an  <= ~sel_s;
                    seg <= suppress_s ? 7'h7F : decode(nib_s);
                    dp  <= ~dpreq_s;
                end
            end else begin
                idx_r <= idx_r;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan with SCAN_DIV=4, NUM_DIGITS=4.
module tb_seg7_scan;

    logic        clk;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int tests;
    int fails;

    seg7_scan #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .digits (digits),
        .dp_in  (dp_in),
        .blank  (blank),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] e_an,
                         input logic [6:0] e_seg, input logic e_dp);
        tests++;
        assert (an === e_an) else begin
            fails++;
            $error("FAIL %s an: observed %b expected %b", tag, an, e_an);
        end
        tests++;
        assert (seg === e_seg) else begin
            fails++;
            $error("FAIL %s seg: observed %h expected %h", tag, seg, e_seg);
        end
        tests++;
        assert (dp === e_dp) else begin
            fails++;
            $error("FAIL %s dp: observed %b expected %b", tag, dp, e_dp);
        end
    endtask

    // Check n consecutive cycles, sampled on the falling edge.
    task automatic hold(input string tag, input int n, input logic [3:0] e_an,
                        input logic [6:0] e_seg, input logic e_dp);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check(tag, e_an, e_seg, e_dp);
        end
    endtask

    logic [6:0] lz_dark;

    initial begin
        tests  = 0;
        fails  = 0;
`ifdef SEG7_LZ_BLANK_EN
        lz_dark = 7'h7F;
`else
        lz_dark = 7'h40;
`endif
        rst    = 1'b1;
        digits = 16'h1234;
        dp_in  = 4'b0000;
        blank  = 1'b0;

        // 1: reset held three cycles, then three more dark cycles after release
        repeat (3) @(negedge clk);
        check("reset_held", 4'hF, 7'h7F, 1'b1);
        rst = 1'b0;
        hold("reset_release", 3, 4'hF, 7'h7F, 1'b1);

        // 2: scan order for 1234, four cycles per slot, wraps around
        hold("scan_d1", 4, 4'b1101, 7'h30, 1'b1);
        hold("scan_d2", 4, 4'b1011, 7'h24, 1'b1);
        hold("scan_d3", 4, 4'b0111, 7'h79, 1'b1);
        hold("scan_d0", 4, 4'b1110, 7'h19, 1'b1);
        hold("scan_d1_again", 4, 4'b1101, 7'h30, 1'b1);

        // 3: hex digits and a decimal point on digit 2
        digits = 16'hABCF;
        dp_in  = 4'b0100;
        hold("hex_d2", 4, 4'b1011, 7'h03, 1'b0);
        hold("hex_d3", 4, 4'b0111, 7'h08, 1'b1);
        hold("hex_d0", 4, 4'b1110, 7'h0E, 1'b1);
        hold("hex_d1", 4, 4'b1101, 7'h46, 1'b1);

        // 4: blank for one slot, then resume on the next digit without skipping
        blank = 1'b1;
        hold("blank_slot", 4, 4'hF, 7'h7F, 1'b1);
        blank = 1'b0;
        hold("blank_resume_d3", 4, 4'b0111, 7'h08, 1'b1);
        hold("blank_resume_d0", 4, 4'b1110, 7'h0E, 1'b1);
        hold("blank_resume_d1", 4, 4'b1101, 7'h46, 1'b1);

        // 5: reset pulse in the middle of digit 2's slot
        hold("pre_reset_d2", 2, 4'b1011, 7'h03, 1'b0);
        rst = 1'b1;
        hold("midscan_reset", 1, 4'hF, 7'h7F, 1'b1);
        rst = 1'b0;
        hold("restart_dark", 3, 4'hF, 7'h7F, 1'b1);
        hold("restart_d1", 4, 4'b1101, 7'h46, 1'b1);

        // 6: leading zeros in 0050
        digits = 16'h0050;
        dp_in  = 4'b0000;
        hold("lz_d2", 4, 4'b1011, lz_dark, 1'b1);
        hold("lz_d3", 4, 4'b0111, lz_dark, 1'b1);
        hold("lz_d0", 4, 4'b1110, 7'h40, 1'b1);
        hold("lz_d1", 4, 4'b1101, 7'h12, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
